// File: rtl/elevator_car_controller.sv
`default_nettype none
// ============================================================================
// Module  : elevator_car_controller
// Brief   : Single-car motion controller: pending-floor bitmap, collective
//           up/down scheduling, per-floor travel timer and door dwell timer.
// Revision: 1.0 - initial release
// ============================================================================
module elevator_car_controller #(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [2:0] req_floor,
  input  logic       req_dir,
  output logic       req_ready,
  output logic [2:0] current_floor,
  output logic       current_dir,
  output logic       moving,
  output logic       door_open,
  output logic       arrived_valid,
  output logic [2:0] arrived_floor
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
  localparam logic [1:0] S_DOOR = 2'd2;

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  logic [1:0]    state_q, state_d;
  logic [7:0]    pending_q, pending_d;
  logic [2:0]    floor_q, floor_d;
  logic          dir_q, dir_d;
  logic [TW-1:0] travel_q, travel_d;
  logic [DW-1:0] door_q, door_d;
  logic          arr_valid_q, arr_valid_d;
  logic [2:0]    arr_floor_q, arr_floor_d;

  logic          accept;
  logic [7:0]    set_mask;
  logic [7:0]    clr_mask;
  logic [2:0]    step_floor;
  logic          unused_req_dir;

  assign unused_req_dir = req_dir;

  function automatic logic work_ahead(input logic [7:0] pend, input logic [2:0] flr,
                                      input logic up);
    logic found;
    found = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pend[i[2:0]] && ((up && (i > int'(flr))) || (!up && (i < int'(flr))))) begin
        found = 1'b1;
      end
    end
    return found;
  endfunction

  // Saturating one-floor step in the committed direction.
  always_comb begin
    step_floor = floor_q;
    if (dir_q) begin
      if (floor_q < 3'(NUM_FLOORS - 1)) step_floor = floor_q + 3'd1;
    end else begin
      if (floor_q != 3'd0) step_floor = floor_q - 3'd1;
    end
  end

  always_comb begin
    req_ready = !rst;
    accept    = req_valid && req_ready && (int'(req_floor) < NUM_FLOORS);
    set_mask  = 8'd0;
    if (accept && !((state_q == S_DOOR) && (req_floor == floor_q))) begin
      set_mask = 8'd1 << req_floor;
    end

    state_d     = state_q;
    floor_d     = floor_q;
    dir_d       = dir_q;
    travel_d    = travel_q;
    door_d      = door_q;
    arr_valid_d = 1'b0;
    arr_floor_d = arr_floor_q;
    clr_mask    = 8'd0;

    case (state_q)
      S_IDLE: begin
        if (pending_q[floor_q]) begin
          state_d     = S_DOOR;
          clr_mask    = 8'd1 << floor_q;
          arr_valid_d = 1'b1;
          arr_floor_d = floor_q;
          door_d      = '0;
        end else if (pending_q != 8'd0) begin
          state_d  = S_MOVE;
          travel_d = '0;
          if (!work_ahead(pending_q, floor_q, dir_q)) dir_d = !dir_q;
        end
      end
      S_MOVE: begin
        if (int'(travel_q) == TRAVEL_CYCLES - 1) begin
          floor_d = step_floor;
          if (pending_q[step_floor]) begin
            state_d     = S_DOOR;
            clr_mask    = 8'd1 << step_floor;
            arr_valid_d = 1'b1;
            arr_floor_d = step_floor;
            door_d      = '0;
          end else if (work_ahead(pending_q, step_floor, dir_q)) begin
            travel_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          travel_d = travel_q + TW'(1);
        end
      end
      S_DOOR: begin
        if (int'(door_q) == DOOR_CYCLES - 1) begin
          state_d = S_IDLE;
        end else begin
          door_d = door_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A request landing on the floor being cleared this edge is absorbed.
    pending_d = (pending_q | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pending_q   <= 8'd0;
      floor_q     <= 3'd0;
      dir_q       <= 1'b1;
      travel_q    <= '0;
      door_q      <= '0;
      arr_valid_q <= 1'b0;
      arr_floor_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      floor_q     <= floor_d;
      dir_q       <= dir_d;
      travel_q    <= travel_d;
      door_q      <= door_d;
      arr_valid_q <= arr_valid_d;
      arr_floor_q <= arr_floor_d;
    end
  end

  assign current_floor = floor_q;
  assign current_dir   = dir_q;
  assign moving        = (state_q == S_MOVE);
  assign door_open     = (state_q == S_DOOR);
  assign arrived_valid = arr_valid_q;
  assign arrived_floor = arr_floor_q;

endmodule
`default_nettype wire

// File: tb/tb_elevator_car_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_elevator_car_controller
// Brief   : Self-checking bench: behavioural car model compared every cycle,
//           directed scenarios with literal expectations, random traffic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_elevator_car_controller;

  localparam int NF = 8;
  localparam int TC = 4;
  localparam int DC = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_floor = 3'd0;
  logic       req_dir = 1'b0;
  logic       req_ready;
  logic [2:0] current_floor;
  logic       current_dir;
  logic       moving;
  logic       door_open;
  logic       arrived_valid;
  logic [2:0] arrived_floor;

  always #5 clk = ~clk;

  elevator_car_controller #(
    .NUM_FLOORS(NF), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_floor(req_floor),
    .req_dir(req_dir), .req_ready(req_ready), .current_floor(current_floor),
    .current_dir(current_dir), .moving(moving), .door_open(door_open),
    .arrived_valid(arrived_valid), .arrived_floor(arrived_floor)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural car model: phase 0 = parked, 1 = travelling, 2 = door open.
  int  m_phase = 0;
  int  m_floor = 0;
  bit  m_dir = 1'b1;
  bit  m_pend[NF];
  int  m_travel_left = 0;
  int  m_door_left = 0;
  bit  m_arr = 1'b0;
  int  m_arr_floor = 0;
  int  pre_phase, pre_floor, cleared, rf;
  bit  acc;

  bit  check_en = 1'b0;
  int  arr_log[$];
  bit  saw_moving = 1'b0;
  int  door_cycles = 0;

  function automatic bit m_ahead(int f, bit d);
    for (int i = 0; i < NF; i++) if (m_pend[i] && (d ? (i > f) : (i < f))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_any();
    for (int i = 0; i < NF; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task m_stop();
    m_pend[m_floor] = 1'b0;
    cleared         = m_floor;
    m_phase         = 2;
    m_door_left     = DC;
    m_arr           = 1'b1;
    m_arr_floor     = m_floor;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_floor = 0; m_dir = 1'b1; m_travel_left = 0; m_door_left = 0;
      m_arr = 1'b0; m_arr_floor = 0;
      for (int i = 0; i < NF; i++) m_pend[i] = 1'b0;
    end else begin
      acc       = req_valid && (int'(req_floor) < NF);
      rf        = int'(req_floor);
      pre_phase = m_phase;
      pre_floor = m_floor;
      cleared   = -1;
      m_arr     = 1'b0;
      case (m_phase)
        0: begin
          if (m_pend[m_floor]) m_stop();
          else if (m_any()) begin
            if (!m_ahead(m_floor, m_dir)) m_dir = !m_dir;
            m_phase       = 1;
            m_travel_left = TC;
          end
        end
        1: begin
          m_travel_left--;
          if (m_travel_left == 0) begin
            if (m_dir) m_floor = (m_floor < NF - 1) ? m_floor + 1 : m_floor;
            else       m_floor = (m_floor > 0) ? m_floor - 1 : 0;
            if (m_pend[m_floor]) m_stop();
            else if (m_ahead(m_floor, m_dir)) m_travel_left = TC;
            else m_phase = 0;
          end
        end
        default: begin
          m_door_left--;
          if (m_door_left == 0) m_phase = 0;
        end
      endcase
      if (acc && rf != cleared && !(pre_phase == 2 && rf == pre_floor)) m_pend[rf] = 1'b1;
    end
  end

  // Per-cycle comparison against the model, plus event logging for scenarios.
  always @(negedge clk) begin
    if (check_en) begin
      logic [10:0] act, exp;
      act = {req_ready, current_floor, current_dir, moving, door_open, arrived_valid,
             arrived_floor & {3{m_arr}}};
      exp = {!rst, 3'(m_floor), m_dir, (m_phase == 1), (m_phase == 2), m_arr,
             3'(m_arr_floor) & {3{m_arr}}};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL model_cycle t=%0t actual=%b required=%b (rdy,floor,dir,mov,door,arr,afloor)",
                 $time, act, exp);
      end
      if (arrived_valid) arr_log.push_back(int'(arrived_floor));
      if (moving) saw_moving = 1'b1;
      if (door_open) door_cycles++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic send(int f);
    req_valid = 1'b1;
    req_floor = 3'(f);
    req_dir   = 1'($urandom_range(0, 1));
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic wait_quiet(int maxc);
    int k;
    k = 0;
    while (!(m_phase == 0 && !m_any()) && k < maxc) begin
      cyc();
      k++;
    end
    if (k >= maxc) check("wait_quiet_timeout", k, -1);
    cyc();
  endtask

  task automatic wait_floor_moving(int f, int maxc);
    int k;
    k = 0;
    while (!(int'(current_floor) == f && moving) && k < maxc) begin
      cyc();
      k++;
    end
    if (k >= maxc) check("wait_floor_timeout", k, -1);
  endtask

  task automatic check_log(string name, int n, int a0, int a1, int a2);
    int e[3];
    e = '{a0, a1, a2};
    check({name, "_stops"}, arr_log.size(), n);
    for (int i = 0; i < n && i < arr_log.size(); i++) check(name, arr_log[i], e[i]);
  endtask

  initial begin
    // Reset and idle hold.
    cyc();
    check_en = 1'b1;
    check("ready_in_reset", int'(req_ready), 0);
    rst = 1'b0;
    cyc();
    check("reset_state", int'({current_floor, current_dir, door_open, req_ready}), 5'b000_1_0_1);
    repeat (50) cyc();
    check("idle_hold", int'({current_floor, current_dir, moving, door_open}), 6'b000_1_0_0);

    // Same-floor request while parked.
    arr_log.delete();
    saw_moving = 1'b0;
    send(0);
    wait_quiet(50);
    check_log("same_floor", 1, 0, 0, 0);
    check("same_floor_no_motion", int'(saw_moving), 0);

    // Single trip with cycle-exact timeline.
    do_reset();
    req_valid = 1'b1;
    req_floor = 3'd3;
    cyc();
    req_valid = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      int ef;
      ef = (c < 6) ? 0 : (c < 10) ? 1 : (c < 14) ? 2 : 3;
      check($sformatf("trip_c%0d", c),
            int'({moving, door_open, arrived_valid, current_floor}),
            ((c >= 2 && c <= 13) ? 32 : 0) + ((c >= 14 && c <= 19) ? 16 : 0) +
            ((c == 14) ? 8 : 0) + ef);
      if (c == 14) check("trip_arr_floor", int'(arrived_floor), 3);
      cyc();
    end

    // Collective ordering.
    do_reset();
    arr_log.delete();
    send(6);
    wait_floor_moving(2, 100);
    send(4);
    send(1);
    wait_quiet(300);
    check_log("collective", 3, 4, 6, 1);
    check("collective_dir", int'(current_dir), 0);

    // Duplicate merge.
    arr_log.delete();
    req_valid = 1'b1;
    req_floor = 3'd5;
    repeat (3) cyc();
    req_valid = 1'b0;
    wait_quiet(300);
    check_log("merge", 1, 5, 0, 0);

    // Request for the current floor while the door is open.
    arr_log.delete();
    door_cycles = 0;
    send(3);
    begin
      int k;
      k = 0;
      while (!door_open && k < 200) begin cyc(); k++; end
      if (k >= 200) check("door_wait_timeout", k, -1);
    end
    cyc();
    send(3);
    wait_quiet(300);
    check_log("door_absorb", 1, 3, 0, 0);
    check("door_cycles", door_cycles, DC);

    // Top and bottom floors.
    arr_log.delete();
    send(7);
    wait_quiet(300);
    send(0);
    wait_quiet(300);
    check_log("bounds", 2, 7, 0, 0);

    // Reset mid-travel.
    send(6);
    wait_floor_moving(3, 200);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midreset_floor", int'({current_floor, moving, door_open}), 0);
    saw_moving = 1'b0;
    repeat (20) cyc();
    check("midreset_no_motion", int'(saw_moving), 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      req_valid = ($urandom_range(0, 99) < 15);
      req_floor = 3'($urandom_range(0, NF - 1));
      req_dir   = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 399) == 0);
      cyc();
    end
    req_valid = 1'b0;
    rst = 1'b0;
    wait_quiet(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/elevator_car_controller.md
Name: elevator_car_controller

Overview:
Per-car motion controller that consumes hall requests from the building dispatcher and moves one elevator car. It holds a pending-floor bitmap and steps the car floor by floor with a travel timer. It opens the door on arrival for a fixed dwell. Its current_floor and current_dir outputs feed back to the dispatcher's per-elevator inputs.

Parameters:
NUM_FLOORS, 8, number of floors; floor indices 0..NUM_FLOORS-1; must be <= 8 (3-bit floor encoding).
TRAVEL_CYCLES, 4, clock cycles to travel between adjacent floors; >= 1.
DOOR_CYCLES, 6, clock cycles the door stays open per stop; >= 1.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request present from dispatcher or car panel.
req_floor  input  3  requested floor.
req_dir  input  1  requested hall direction (1=up, 0=down); informational, not used for scheduling.
req_ready  output  1  controller can accept a request this cycle.
current_floor  output  3  floor the car is at or last passed.
current_dir  output  1  travel or committed direction, 1=up, 0=down.
moving  output  1  high in MOVE state.
door_open  output  1  high in DOOR state.
arrived_valid  output  1  one-cycle pulse on each stop.
arrived_floor  output  3  floor of the stop; valid with arrived_valid.

Behaviour:
- Reset values: state IDLE, pending=0, current_floor=0, current_dir=1, moving=0, door_open=0, arrived_valid=0, arrived_floor=0, timers=0, req_ready=0 during the reset cycle.
- Handshake: req_ready=1 in every non-reset cycle. A request is accepted on valid&ready.
  - Accepted req_floor >= NUM_FLOORS is dropped.
  - Otherwise pending[req_floor] is set at the next edge. A duplicate of an already-pending floor merges.
- "Ahead" means any pending bit strictly above current_floor when current_dir=1, or strictly below when current_dir=0.
- IDLE:
  - pending=0: stay in IDLE.
  - pending[current_floor]=1: go to DOOR. Clear the bit and pulse arrived_valid.
  - Else if ahead: go to MOVE, keeping current_dir.
  - Else: flip current_dir and go to MOVE.
  - The transition takes effect at the next edge. IDLE lasts at least 1 cycle when work exists.
- MOVE:
  - Travel timer counts TRAVEL_CYCLES cycles.
  - In the last cycle, the next edge steps current_floor by +1 (dir=1) or -1 (dir=0).
  - If the new floor is pending: go to DOOR, clear the bit, and assert arrived_valid=1 with arrived_floor equal to the new floor, in the first cycle current_floor shows the new floor.
  - Else if work remains ahead of the new floor: stay in MOVE and restart the timer.
  - Else: go to IDLE.
  - Floor never goes below 0 or above NUM_FLOORS-1. The direction rule guarantees this; the RTL also saturates.
- DOOR:
  - door_open=1 for exactly DOOR_CYCLES cycles, then go to IDLE.
  - A request for current_floor accepted while in DOOR is absorbed: bit not set, no extra pulse, timer unchanged.
- Simultaneous events:
  - A request accepted in the same cycle its floor is being cleared on arrival is absorbed; clear wins.
  - A request for another floor in any cycle is always recorded.
- Passing floors: a floor requested behind the car is served only after a direction reversal (collective control).
- current_dir changes only in IDLE. It holds its value through MOVE and DOOR.
- Reset mid-operation: any state, including mid-travel or door open, returns to reset values at the next edge. Pending requests are discarded.

Test Plan:
- Reset, idle: after rst, current_floor=0, current_dir=1, door_open=0, req_ready=1; with no requests, state holds for 50 cycles.
- Single trip: at floor 0, accept req_floor=3.
  - Expected: moving from cycle 2; current_floor 1/2/3 at cycles 6/10/14.
  - Expected: arrived_valid and arrived_floor=3 at cycle 14; door_open for cycles 14-19; IDLE at 20.
- Same-floor request at idle: at floor 0, request 0 -> DOOR with arrived_floor=0, no movement.
- Collective order: at floor 2 moving up toward 6, inject requests 4 and 1 -> stops at 4 then 6, then reverses to dir=0 and stops at 1.
- Absorb and merge:
  - Request 5 repeated 3 times -> exactly one stop at 5.
  - A request for the current floor during door_open -> no extra arrived pulse; door closes after 6 cycles.
- Bounds and reset:
  - Request 7, then 0 -> floor never exceeds 7 or goes below 0.
  - Assert rst mid-MOVE at floor 3 -> next cycle floor=0, pending cleared, no further motion.
